// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shift register with a valid/ready load handshake.
// One bit leaves per shift_en cycle; serial_out/serial_valid are registered.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

    // state   | meaning
    // S_IDLE  | line parked at 0, waiting for a load handshake
    // S_SHIFT | word in shreg, one bit consumed per shift_en cycle
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_nxt;
    logic             serial_out_nxt;
    logic             serial_valid_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            shreg        <= shreg_nxt;
            bit_cnt      <= bit_cnt_nxt;
            serial_out   <= serial_out_nxt;
            serial_valid <= serial_valid_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
        end
    end

    // The bit after the current one sits at the head of the shifted word.
    always_comb begin
        shreg_shifted = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
    end

    always_comb begin
        state_nxt        = state;
        shreg_nxt        = shreg;
        bit_cnt_nxt      = bit_cnt;
        serial_out_nxt   = serial_out;
        serial_valid_nxt = serial_valid;
        busy_nxt         = busy;
        done_nxt         = 1'b0;
        case (state)
            S_IDLE: begin
                serial_out_nxt   = 1'b0;
                serial_valid_nxt = 1'b0;
                busy_nxt         = 1'b0;
                if (load_valid) begin
                    state_nxt        = S_SHIFT;
                    shreg_nxt        = data_in;
                    bit_cnt_nxt      = '0;
                    serial_out_nxt   = head_bit(data_in);
                    serial_valid_nxt = 1'b1;
                    busy_nxt         = 1'b1;
                end
            end
            S_SHIFT: begin
                if (shift_en) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt        = S_IDLE;
                        serial_out_nxt   = 1'b0;
                        serial_valid_nxt = 1'b0;
                        busy_nxt         = 1'b0;
                        done_nxt         = 1'b1;
                    end else begin
                        shreg_nxt      = shreg_shifted;
                        bit_cnt_nxt    = bit_cnt + CNT_W'(1);
                        serial_out_nxt = head_bit(shreg_shifted);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        load_ready = (state == S_IDLE) && !reset;
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share stimulus,
// a word-level model is compared every cycle, and directed cases pin literal sequences.
module tb_piso_serializer;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid;
    logic [W-1:0] data_in;
    logic         shift_en;
    logic [1:0]   lr, so, sv, bz, dn;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(lr[0]),
        .data_in(data_in), .shift_en(shift_en), .serial_out(so[0]),
        .serial_valid(sv[0]), .busy(bz[0]), .done(dn[0])
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(lr[1]),
        .data_in(data_in), .shift_en(shift_en), .serial_out(so[1]),
        .serial_valid(sv[1]), .busy(bz[1]), .done(dn[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word-level model: active flag, current word and index of the bit on the line.
    bit           m_act [2];
    logic [W-1:0] m_word[2];
    int           m_pos [2];
    bit           m_done[2];

    function automatic logic exp_bit(input logic [W-1:0] w, input int pos, input bit msb);
        return msb ? w[W-1-pos] : w[pos];
    endfunction

    int           cyc = 0;
    int           t_load = 0;
    int           last_done = 0;
    int           n_loads = 0;
    int           n_dones = 0;
    bit           cap0[$];
    bit           cap1[$];
    logic [W-1:0] sipo = '0;
    logic [W-1:0] rx_q[$];
    bit           chk_en = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (!reset && load_valid && lr[0]) begin
            t_load = cyc;
            n_loads++;
        end
        if (!reset && shift_en && sv[0]) begin
            cap0.push_back(so[0]);
            sipo = {sipo[W-2:0], so[0]};
        end
        if (!reset && shift_en && sv[1]) cap1.push_back(so[1]);
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            if (reset) begin
                m_act[i] = 1'b0;
                m_pos[i] = 0;
            end else if (!m_act[i]) begin
                if (load_valid) begin
                    m_act[i]  = 1'b1;
                    m_word[i] = data_in;
                    m_pos[i]  = 0;
                end
            end else if (shift_en) begin
                if (m_pos[i] == W - 1) begin
                    m_act[i]  = 1'b0;
                    m_done[i] = 1'b1;
                end else begin
                    m_pos[i]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [4:0] act, exp;
                act = {lr[i], so[i], sv[i], bz[i], dn[i]};
                exp = {!m_act[i] && !reset,
                       m_act[i] ? exp_bit(m_word[i], m_pos[i], (i == 0)) : 1'b0,
                       m_act[i], m_act[i], m_done[i]};
                check(i == 0 ? "cycle_msb {ready,out,valid,busy,done}" :
                               "cycle_lsb {ready,out,valid,busy,done}", 32'(act), 32'(exp));
            end
            if (dn[0]) begin
                n_dones++;
                last_done = cyc;
                rx_q.push_back(sipo);
                check("loopback_rx_word", 32'(sipo), 32'(m_word[0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!dn[0] && k < budget);
        if (!dn[0]) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done: no done within %0d cycles", budget);
        end
    endtask

    function automatic logic [W-1:0] q2v(input bit q[$]);
        logic [W-1:0] v = '0;
        for (int i = 0; i < q.size() && i < W; i++) v = {v[W-2:0], q[i]};
        return v;
    endfunction

    initial begin
        int d0, np;
        bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};

        reset = 1'b1; load_valid = 1'b0; data_in = '0; shift_en = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        check("reset_outputs", 32'({lr, so, sv, bz, dn}), 32'h0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(lr), 32'h3);

        // MSB/LSB word 1011, shift_en tied high
        cap0.delete(); cap1.delete();
        d0 = n_dones;
        load_valid = 1'b1; data_in = 4'b1011; shift_en = 1'b1;
        tick();
        load_valid = 1'b0;
        wait_done(20);
        check("msb_done_latency", 32'(cyc - t_load), 32'd4);
        repeat (3) tick();
        check("msb_bits_1011", 32'(q2v(cap0)), 32'b1011);
        check("lsb_bits_1101", 32'(q2v(cap1)), 32'b1101);
        check("single_done", 32'(n_dones - d0), 32'd1);

        // stalled pacing
        cap0.delete(); cap1.delete();
        load_valid = 1'b1; data_in = 4'b0110; shift_en = 1'b0;
        tick();
        load_valid = 1'b0;
        foreach (pat[i]) begin
            shift_en = pat[i];
            tick();
        end
        shift_en = 1'b0;
        @(negedge clk);
        check("stall_done_now", 32'(dn), 32'h3);
        check("stall_done_latency", 32'(cyc - t_load), 32'd7);
        check("stall_msb_bits", 32'(q2v(cap0)), 32'b0110);
        check("stall_lsb_bits", 32'(q2v(cap1)), 32'b0110);

        // back-to-back loads with SIPO loopback
        tick();
        np = n_loads;
        load_valid = 1'b1; data_in = 4'hA; shift_en = 1'b1;
        tick();
        data_in = 4'h5;
        for (int k = 0; k < 20 && n_loads < np + 2; k++) tick();
        load_valid = 1'b0;
        check("b2b_accept_on_done", 32'(t_load - last_done), 32'd1);
        wait_done(20);
        repeat (2) tick();
        check("b2b_load_count", 32'(n_loads - np), 32'd2);
        check("rx_first_A", 32'(rx_q.size() >= 2 ? rx_q[rx_q.size()-2] : 4'hF), 32'hA);
        check("rx_second_5", 32'(rx_q.size() >= 1 ? rx_q[rx_q.size()-1] : 4'hF), 32'h5);

        // reset mid-stream with random inputs
        load_valid = 1'b1; data_in = 4'b1001; shift_en = 1'b1;
        tick();
        load_valid = 1'b0;
        tick();
        for (int r = 0; r < 2; r++) begin
            reset = 1'b1;
            load_valid = 1'($urandom); data_in = W'($urandom); shift_en = 1'($urandom);
            tick();
            @(negedge clk);
            check("reset_midstream_zero", 32'({lr, so, sv, bz, dn}), 32'h0);
        end
        tick();
        reset = 1'b0; load_valid = 1'b0; shift_en = 1'b0;
        @(negedge clk);
        check("ready_after_midreset", 32'(lr), 32'h3);

        // abort after two bits, then a clean word
        d0 = n_dones;
        load_valid = 1'b1; data_in = 4'b1100; shift_en = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0; shift_en = 1'b0;
        @(negedge clk);
        check("abort_no_done", 32'(n_dones - d0), 32'd0);
        check("abort_valid_low", 32'(sv), 32'h0);
        tick();
        cap0.delete(); cap1.delete();
        load_valid = 1'b1; data_in = 4'b0011; shift_en = 1'b1;
        tick();
        load_valid = 1'b0;
        wait_done(20);
        tick();
        check("after_abort_msb_0011", 32'(q2v(cap0)), 32'b0011);
        check("after_abort_lsb_1100", 32'(q2v(cap1)), 32'b1100);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            reset      = ($urandom_range(0, 39) == 0);
            load_valid = 1'($urandom);
            data_in    = W'($urandom);
            shift_en   = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset = 1'b0; load_valid = 1'b0; shift_en = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
